// File: rtl/tns_dec_ctrl.sv
// Frame decode sequencer for the tribonacci-weighted 9-bit codeword path.
// One shared weighted-sum decoder is stepped across the lanes, one lane per cycle.
module tns_dec_ctrl #(
    parameter int LANES = 4,
    parameter int DW    = 9,
    parameter int W0    = 1,
    parameter int W1    = 2,
    parameter int W2    = 4,
    parameter int W3    = 7,
    parameter int W4    = 13,
    parameter int W5    = 24,
    parameter int W6    = 44,
    parameter int W7    = 81,
    parameter int W8    = 149,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*9-1:0]    in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_err,
    input  logic                  clr_cnt,
    output logic [CW-1:0]         err_cnt
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam int WT [9] = '{W0, W1, W2, W3, W4, W5, W6, W7, W8};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [IW-1:0]        idx_r;
    logic [LANES*9-1:0]   frame_r;
    logic [8:0]           lane_code_s;
    logic [31:0]          pop_s;
    logic [CW-1:0]        headroom_s;
    logic [CW-1:0]        cnt_add_s;

    function automatic logic [DW-1:0] tns_decode(input logic [8:0] code);
        logic [31:0] acc;
        acc = 32'd0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + (code[k] ? 32'(WT[k]) : 32'd0);
        end
        return acc[DW-1:0];
    endfunction

    function automatic logic has_run3(input logic [8:0] code);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 7; k++) begin
            r = r | (&code[k +: 3]);
        end
        return r;
    endfunction

    function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Lane selection for the shared decoder and saturating error-count sum.
    always_comb begin
        lane_code_s = frame_r[32'(idx_r) * 32'd9 +: 9];
        pop_s       = popcount(out_err);
        headroom_s  = CNT_MAX - err_cnt;
        if (64'(pop_s) > 64'(headroom_s)) begin
            cnt_add_s = CNT_MAX;
        end else begin
            cnt_add_s = err_cnt + CW'(pop_s);
        end
    end

    // Frame sequencer: capture, per-lane decode, hold until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IW{1'b0}};
            frame_r   <= {(LANES*9){1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= {(LANES*DW){1'b0}};
            out_err   <= {LANES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        frame_r  <= in_code;
                        idx_r    <= {IW{1'b0}};
                        out_err  <= {LANES{1'b0}};
                        in_ready <= 1'b0;
                        state_r  <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    out_data[32'(idx_r) * DW +: DW] <= tns_decode(lane_code_s);
                    out_err[idx_r]                  <= has_run3(lane_code_s);
                    if (idx_r == IDX_LAST) begin
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Violation counter; a clear beats a coincident frame transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= {CW{1'b0}};
        end else if (clr_cnt) begin
            err_cnt <= {CW{1'b0}};
        end else if ((state_r == ST_DONE) && out_ready) begin
            err_cnt <= cnt_add_s;
        end
    end

endmodule
